noc_output_scheduler: RTL and testbench
=======================================

// Module: noc_output_scheduler
// PURPOSE
// - Packet-level scheduler for one router output port: shares the port between the five inputs (L,N,E,W,S).
// - Grants the crossbar to one input from header flit to tail flit (wormhole), under credit-based flow control.
// - One instance per output port, between the input buffers and the crossbar mux select.
// PARAMETERS
// - CREDITS         4    downstream buffer depth in flits; reset value of the credit counter
// - CRED_W          3    credit counter width; must hold CREDITS (>= clog2(CREDITS+1))
// - TIMEOUT_CYCLES  64   stall cycles before a held grant is revoked (used only with ARB_TIMEOUT_EN)
// - TO_W            12   stall counter width
// PORTS
// - clk            in   1        clock; all state changes on posedge
// - rst            in   1        synchronous, active-high reset
// - flit_valid_in  in   5        flit present at head of input buffer; bit0=L, 1=N, 2=E, 3=W, 4=S
// - route_hit      in   5        head flit of that input is routed to this output
// - flit_id_in     in   15       3-bit flit id per input, input i at [3i+2:3i]; bit0=head, bit2=tail
// - credit_in      in   1        downstream freed one buffer slot
// - grant          out  5        one-hot registered owner of the output; 0 when idle
// - xbar_sel       out  3        encoded grant (0..4) for the crossbar mux; 7 when idle
// - flit_pop       out  5        combinational pop strobe to the owning input buffer
// - flit_send      out  1        combinational valid to downstream; equals |flit_pop
// - credits        out  CRED_W   current credit count
// - credit_err     out  1        sticky: credit_in received while credits==CREDITS
// - timeout        out  1        one-cycle pulse when a grant is revoked (ARB_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
// - Reset values: grant=0, xbar_sel=7, credits=CREDITS, credit_err=0, timeout=0, state IDLE, rr pointer=S.
//   Reset mid-packet drops the grant immediately; no flit is popped in the reset cycle.
// - Eligible request i: flit_valid_in[i] && route_hit[i] && flit_id_in[3i]. A head bit is required.
// - IDLE:
//   - If any request is eligible, pick the first eligible input after the pointer, in cyclic order L,N,E,W,S.
//   - Register the winner into grant and go to BUSY. Grant is visible the next cycle.
//   - Nothing is popped while in IDLE.
// - BUSY, owner g:
//   - flit_pop[g]=flit_valid_in[g] && credits!=0, in the same cycle. The route_hit and head bits are ignored.
//   - If the popped flit has its tail bit set (3'b100, or 3'b101 for a single-flit packet):
//     - next state is IDLE and the pointer is set to g;
//     - grant clears the next cycle.
//   - Minimum latency: eligible request at cycle N, grant and first send at N+1.
//     After a tail at cycle M, the next grant is at M+2.
// - Credits:
//   - A send decrements the counter; credit_in increments it.
//   - A send and credit_in in the same cycle leave it unchanged.
//   - No send occurs at 0.
//   - When full, credit_in without a send saturates the counter and sets credit_err.
// - Encoding: states are one-hot localparams (IDLE, BUSY). xbar_sel is derived from the registered grant.
// CONFIGURATION
// - ARB_TIMEOUT_EN defined:
//   - In BUSY, a stall counter counts cycles without a pop; it clears on every pop and on entry to BUSY.
//   - When it reaches TIMEOUT_CYCLES: timeout pulses, grant is revoked (IDLE next cycle), pointer=g, credits untouched.
// - ARB_TIMEOUT_EN undefined: no stall counter; the grant is held until the tail flit; timeout is a constant 0.
// STRUCTURE
// - Package noc_arb_pkg holds:
//   - port indices L=0..S=4 and NUM_PORTS=5;
//   - flit id constants HEAD=3'b001, BODY=3'b010, TAIL=3'b100, HEADTAIL=3'b101;
//   - state encodings ST_IDLE/ST_BUSY;
//   - XBAR_IDLE=3'd7.
// - Sub-module rr_arbiter5: combinational, 5-bit request plus pointer in; one-hot winner plus any out.
//   The scheduler owns the pointer register.
// TESTING
// - Single request, 3-flit packet, full credits:
//   - stimulus: L asserts HEAD, BODY, TAIL back-to-back;
//   - grant=5'b00001 and xbar_sel=0 from cycle 1, flit_pop[0] in cycles 1-3, credits 4->1, grant=0 at cycle 4.
// - Round robin:
//   - stimulus: L, E, S request continuously with single-flit packets (3'b101);
//   - grants in order L, E, S, L, spaced 2 cycles apart.
// - Credit stall:
//   - stimulus: CREDITS=4, 6-flit packet from N, no credit_in;
//   - 4 sends, then flit_send=0 with grant held;
//   - one credit_in pulse gives exactly one more send.
// - Simultaneous events:
//   - send and credit_in in the same cycle at credits=2 -> credits stays 2;
//   - credit_in at credits=4 with no send -> credits=4, credit_err=1, and it stays set.
// - Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64):
//   - stimulus: W is granted, sends a HEAD, then flit_valid_in[3]=0;
//   - timeout pulses at stall cycle 64, grant=0 next cycle, then the pending E request wins.
// - Reset mid-packet: rst during BODY -> grant=0, xbar_sel=7, credits=4 next cycle, no pop in the rst cycle.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared constants, state encodings and helpers for the NoC output-port scheduler.
package noc_arb_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PORT_L    = 0;
    localparam int unsigned PORT_N    = 1;
    localparam int unsigned PORT_E    = 2;
    localparam int unsigned PORT_W    = 3;
    localparam int unsigned PORT_S    = 4;

    localparam logic [2:0] HEAD      = 3'b001;
    localparam logic [2:0] BODY      = 3'b010;
    localparam logic [2:0] TAIL      = 3'b100;
    localparam logic [2:0] HEADTAIL  = 3'b101;
    localparam logic [2:0] XBAR_IDLE = 3'd7;

    // One-hot state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_BUSY = 2'b10
    } state_e;

    // Encodes a one-hot port vector; XBAR_IDLE when no bit is set.
    function automatic logic [2:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        logic [2:0] idx;
        idx = XBAR_IDLE;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_output_scheduler_if.sv
// Input-buffer / crossbar / downstream-credit signals of one scheduled output port.
interface noc_output_scheduler_if
    import noc_arb_pkg::*;
#(
    parameter int unsigned CRED_W = 3
);
    logic [NUM_PORTS-1:0]   flit_valid_in;
    logic [NUM_PORTS-1:0]   route_hit;
    logic [3*NUM_PORTS-1:0] flit_id_in;
    logic                   credit_in;
    logic [NUM_PORTS-1:0]   grant;
    logic [2:0]             xbar_sel;
    logic [NUM_PORTS-1:0]   flit_pop;
    logic                   flit_send;
    logic [CRED_W-1:0]      credits;
    logic                   credit_err;
    logic                   timeout;

    modport master (
        input  flit_valid_in, route_hit, flit_id_in, credit_in,
        output grant, xbar_sel, flit_pop, flit_send, credits, credit_err, timeout
    );

    modport slave (
        output flit_valid_in, route_hit, flit_id_in, credit_in,
        input  grant, xbar_sel, flit_pop, flit_send, credits, credit_err, timeout
    );
endinterface

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: picks the first request strictly after ptr_i in cyclic order L,N,E,W,S.
module rr_arbiter5
    import noc_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [2:0]           ptr_i,
    output logic [NUM_PORTS-1:0] gnt_c,
    output logic                 any_c
);
    logic [3:0] idx;
    logic       found;

    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = {1'b0, ptr_i} + 4'(k);
            if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
            if (!found && req_i[idx[2:0]]) begin
                gnt_c[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    assign any_c = |req_i;

endmodule

// File: rtl/noc_output_scheduler.sv
// Wormhole packet scheduler for one router output port with credit flow control.
// Optional stall-timeout grant revocation is built when ARB_TIMEOUT_EN is defined.
module noc_output_scheduler
    import noc_arb_pkg::*;
#(
    parameter int unsigned CREDITS        = 4,
    parameter int unsigned CRED_W         = 3
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_W           = 12
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    noc_output_scheduler_if.master bus
);
    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [2:0]           xbar_sel_q, xbar_sel_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [CRED_W-1:0]    credits_q, credits_d;
    logic                 credit_err_q, credit_err_d;

    logic [NUM_PORTS-1:0] req_c, tail_bits_c, pop_c, arb_gnt_c, unused_body_bits;
    logic                 arb_any_c, send_c, tail_c, revoke_c;

    // Eligibility needs a head flit routed here; tail bits matter only for the owner.
    always_comb begin
        req_c            = '0;
        tail_bits_c      = '0;
        unused_body_bits = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req_c[i]            = bus.flit_valid_in[i] & bus.route_hit[i] & bus.flit_id_in[3*i];
            tail_bits_c[i]      = bus.flit_id_in[3*i+2];
            unused_body_bits[i] = bus.flit_id_in[3*i+1];
        end
    end

    rr_arbiter5 u_arb (
        .req_i (req_c),
        .ptr_i (ptr_q),
        .gnt_c (arb_gnt_c),
        .any_c (arb_any_c)
    );

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] stall_q, stall_d;
    logic            timeout_q, timeout_d;

    assign revoke_c = (state_q == ST_BUSY) && (pop_c == '0) &&
                      (stall_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign revoke_c = 1'b0;
`endif

    // Owner pops whenever it has a flit and downstream has room; never during reset.
    always_comb begin
        pop_c = '0;
        if (state_q == ST_BUSY && !rst && credits_q != '0) pop_c = grant_q & bus.flit_valid_in;
    end

    assign send_c = |pop_c;
    assign tail_c = |(pop_c & tail_bits_c);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    state_d = ST_BUSY;
                    grant_d = arb_gnt_c;
                end
            end
            ST_BUSY: begin
                if (tail_c || revoke_c) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = xbar_sel_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        xbar_sel_d = onehot_to_idx(grant_d);
    end

    // Simultaneous send and return cancel; a return into a full counter is an error.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (send_c && !bus.credit_in) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (!send_c && bus.credit_in) begin
            if (credits_q == CRED_W'(CREDITS)) credit_err_d = 1'b1;
            else                               credits_d    = credits_q + CRED_W'(1);
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        stall_d   = '0;
        timeout_d = revoke_c;
        if (state_q == ST_BUSY && !send_c && !revoke_c) stall_d = stall_q + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            xbar_sel_q   <= XBAR_IDLE;
            ptr_q        <= 3'(PORT_S);
            credits_q    <= CRED_W'(CREDITS);
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            xbar_sel_q   <= xbar_sel_d;
            ptr_q        <= ptr_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.xbar_sel   = xbar_sel_q;
    assign bus.flit_pop   = pop_c;
    assign bus.flit_send  = send_c;
    assign bus.credits    = credits_q;
    assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Directed bench for noc_output_scheduler: per-input flit queues feed the DUT, a scoreboard
// holds the flits expected on the output in order. Timeout steps are built with ARB_TIMEOUT_EN.
module tb_noc_output_scheduler;
    import noc_arb_pkg::*;

    typedef struct packed {
        logic [2:0] port;
        logic [2:0] id;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [2:0]           inq [NUM_PORTS][$];
    logic                 vmask [NUM_PORTS];
    logic                 rmask [NUM_PORTS];
    sb_t                  sb [$];
    logic [NUM_PORTS-1:0] last_pop;
    logic [4:0]           exp_rr [9] = '{5'd0, 5'd1, 5'd0, 5'd4, 5'd0, 5'd16, 5'd0, 5'd1, 5'd0};

    noc_output_scheduler_if #(.CRED_W(3)) bus ();

    noc_output_scheduler #(.CREDITS(4), .CRED_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a flit at an input; optionally record it as expected on the output.
    task automatic put(input int p, input logic [2:0] id, input bit expect_send);
        sb_t e;
        inq[p].push_back(id);
        if (expect_send) begin
            e.port = 3'(p);
            e.id   = id;
            sb.push_back(e);
        end
    endtask

    // Advance one cycle: retire popped flits, drive inputs, then score any pop of the new cycle.
    task automatic tick(input logic r = 1'b0, input logic ci = 1'b0);
        sb_t        e;
        logic [2:0] pidx;
        logic [2:0] dummy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (last_pop[i] && inq[i].size() != 0) dummy = inq[i].pop_front();
        end
        rst           = r;
        bus.credit_in = ci;
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.flit_valid_in[i]     = (inq[i].size() != 0) && vmask[i];
            bus.route_hit[i]         = rmask[i];
            bus.flit_id_in[3*i +: 3] = (inq[i].size() != 0) ? inq[i][0] : 3'b000;
        end
        #2;
        last_pop = bus.flit_pop;
        if (last_pop != '0) begin
            pidx = 3'd7;
            for (int i = 0; i < NUM_PORTS; i++) if (last_pop[i]) pidx = 3'(i);
            chk("flit_send_on_pop", 32'(bus.flit_send), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_pop", 32'(last_pop), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pop_port", 32'(pidx), 32'(e.port));
                chk("pop_xbar_sel", 32'(bus.xbar_sel), 32'(e.port));
                chk("pop_flit_id", 32'(bus.flit_id_in[3*pidx +: 3]), 32'(e.id));
            end
        end else begin
            chk("flit_send_idle", 32'(bus.flit_send), 32'd0);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.flit_valid_in = '0;
        bus.route_hit     = '0;
        bus.flit_id_in    = '0;
        bus.credit_in     = 1'b0;
        last_pop          = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            vmask[i] = 1'b1;
            rmask[i] = 1'b1;
        end

        // Reset values
        tick(.r(1'b1));
        tick(.r(1'b1));
        tick();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_xbar_sel", 32'(bus.xbar_sel), 32'd7);
        chk("rst_credits", 32'(bus.credits), 32'd4);
        chk("rst_credit_err", 32'(bus.credit_err), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);

        // Round robin from the reset pointer (S): L, E, S, L, two cycles apart
        put(PORT_L, HEADTAIL, 1); put(PORT_E, HEADTAIL, 1); put(PORT_S, HEADTAIL, 1);
        put(PORT_L, HEADTAIL, 1);
        for (int c = 0; c < 9; c++) begin
            tick();
            chk($sformatf("rr_grant_c%0d", c), 32'(bus.grant), 32'(exp_rr[c]));
        end
        chk("rr_credits_drained", 32'(bus.credits), 32'd0);
        for (int k = 0; k < 4; k++) tick(.ci(1'b1));
        tick();
        chk("rr_credits_restored", 32'(bus.credits), 32'd4);

        // A head flit is required, and the route must hit
        put(PORT_N, BODY, 0);
        for (int k = 0; k < 3; k++) tick();
        chk("no_head_no_grant", 32'(bus.grant), 32'd0);
        inq[PORT_N].delete();
        rmask[PORT_L] = 1'b0;
        put(PORT_L, HEAD, 0);
        for (int k = 0; k < 3; k++) tick();
        chk("no_route_no_grant", 32'(bus.grant), 32'd0);
        inq[PORT_L].delete();
        rmask[PORT_L] = 1'b1;
        tick();

        // Three-flit packet from L with full credits
        put(PORT_L, HEAD, 1); put(PORT_L, BODY, 1); put(PORT_L, TAIL, 1);
        tick();
        chk("pkt_c0_grant", 32'(bus.grant), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("pkt_c%0d_grant", c), 32'(bus.grant), 32'd1);
            chk($sformatf("pkt_c%0d_pop", c), 32'(bus.flit_pop), 32'd1);
            chk($sformatf("pkt_c%0d_credits", c), 32'(bus.credits), 32'(5 - c));
        end
        tick();
        chk("pkt_c4_grant", 32'(bus.grant), 32'd0);
        chk("pkt_c4_xbar_sel", 32'(bus.xbar_sel), 32'd7);
        chk("pkt_c4_credits", 32'(bus.credits), 32'd1);
        for (int k = 0; k < 3; k++) tick(.ci(1'b1));
        tick();
        chk("pkt_credits_restored", 32'(bus.credits), 32'd4);

        // Credit stall: six-flit packet from N with four credits
        put(PORT_N, HEAD, 1);
        for (int k = 0; k < 4; k++) put(PORT_N, BODY, 1);
        put(PORT_N, TAIL, 1);
        tick();
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("stall_c%0d_pop", c), 32'(bus.flit_pop), 32'd2);
        end
        tick();
        chk("stall_c5_pop", 32'(bus.flit_pop), 32'd0);
        chk("stall_c5_grant", 32'(bus.grant), 32'd2);
        chk("stall_c5_credits", 32'(bus.credits), 32'd0);
        tick();
        chk("stall_c6_pop", 32'(bus.flit_pop), 32'd0);
        tick(.ci(1'b1));
        chk("stall_c7_pop", 32'(bus.flit_pop), 32'd0);
        tick();
        chk("stall_c8_credits", 32'(bus.credits), 32'd1);
        chk("stall_c8_pop", 32'(bus.flit_pop), 32'd2);
        tick();
        chk("stall_c9_pop", 32'(bus.flit_pop), 32'd0);
        chk("stall_c9_grant", 32'(bus.grant), 32'd2);

        // Send and credit return in the same cycle at credits=2
        vmask[PORT_N] = 1'b0;
        tick(.ci(1'b1));
        tick(.ci(1'b1));
        tick();
        chk("simul_pre_credits", 32'(bus.credits), 32'd2);
        vmask[PORT_N] = 1'b1;
        tick(.ci(1'b1));
        chk("simul_pop", 32'(bus.flit_pop), 32'd2);
        tick();
        chk("simul_credits", 32'(bus.credits), 32'd2);
        chk("simul_grant_released", 32'(bus.grant), 32'd0);

        // Credit return into a full counter saturates and sets the sticky error
        tick(.ci(1'b1));
        tick(.ci(1'b1));
        tick();
        chk("full_credits", 32'(bus.credits), 32'd4);
        chk("full_err_clear", 32'(bus.credit_err), 32'd0);
        tick(.ci(1'b1));
        tick();
        chk("over_credits", 32'(bus.credits), 32'd4);
        chk("over_err_set", 32'(bus.credit_err), 32'd1);
        tick();
        chk("over_err_sticky", 32'(bus.credit_err), 32'd1);

        // Reset in the middle of a packet
        put(PORT_L, HEAD, 1); put(PORT_L, BODY, 0); put(PORT_L, BODY, 0); put(PORT_L, TAIL, 0);
        tick();
        tick();
        chk("mid_c1_pop", 32'(bus.flit_pop), 32'd1);
        tick(.r(1'b1));
        chk("mid_rst_pop", 32'(bus.flit_pop), 32'd0);
        tick();
        chk("mid_grant", 32'(bus.grant), 32'd0);
        chk("mid_xbar_sel", 32'(bus.xbar_sel), 32'd7);
        chk("mid_credits", 32'(bus.credits), 32'd4);
        chk("mid_credit_err", 32'(bus.credit_err), 32'd0);
        inq[PORT_L].delete();
        tick();

`ifdef ARB_TIMEOUT_EN
        // W stalls after its head; the grant is revoked and pending E then wins
        put(PORT_W, HEAD, 1); put(PORT_W, BODY, 0);
        tick();
        tick();
        chk("to_c1_grant", 32'(bus.grant), 32'd8);
        vmask[PORT_W] = 1'b0;
        put(PORT_E, HEADTAIL, 1);
        for (int k = 0; k < 64; k++) tick();
        chk("to_c65_grant", 32'(bus.grant), 32'd8);
        chk("to_c65_timeout", 32'(bus.timeout), 32'd0);
        tick();
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        chk("to_grant_revoked", 32'(bus.grant), 32'd0);
        tick();
        chk("to_next_grant", 32'(bus.grant), 32'd4);
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        tick();
        inq[PORT_W].delete();
        vmask[PORT_W] = 1'b1;
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
